// File: rtl/oagu_add.sv
// Write-side address generator for the element-wise ADD path.
// Turns the PE ADD result stream into IOB writes while walking the loop nest
// X (innermost) -> piece -> Y, then pulses done for one cycle.
// Optional: define OAGU_ADD_RELU_EN to clamp negative results to zero on write.
module oagu_add #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_Input_PieceNum,
  input  logic [7:0]        i_Out_YLength,
  input  logic [7:0]        i_Out_XLength,
  input  logic [ADDR_W-1:0] i_Out_BaseAddr,
  input  logic              i_AGUStart,
  input  logic              i_PE_Valid,
  input  logic [DATA_W-1:0] i_PE_Data,
  output logic              o_IOB_WEn,
  output logic [ADDR_W-1:0] o_IOB_WAddr,
  output logic [DATA_W-1:0] o_IOB_WData,
  output logic              o_AGU_Busy,
  output logic              o_AGU_Done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [ADDR_W-1:0] AddrOne = 1;

  state_e              r_state;
  logic [7:0]          r_xlen, r_pnum, r_ylen;
  logic [ADDR_W-1:0]   r_base;
  logic [7:0]          r_x, r_piece, r_y;
  logic [ADDR_W-1:0]   r_offset;
  logic                r_wen, r_busy, r_done;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;

  logic                w_empty;
  logic                w_x_max, w_p_max, w_y_max;
  logic [DATA_W-1:0]   w_pe_data;

  // Any zero dimension means there is nothing to write.
  assign w_empty = (i_Out_XLength == 8'd0) || (i_Input_PieceNum == 8'd0) ||
                   (i_Out_YLength == 8'd0);

  assign w_x_max = (r_x == r_xlen - 8'd1);
  assign w_p_max = (r_piece == r_pnum - 8'd1);
  assign w_y_max = (r_y == r_ylen - 8'd1);

`ifdef OAGU_ADD_RELU_EN
  assign w_pe_data = i_PE_Data[DATA_W-1] ? '0 : i_PE_Data;
`else
  assign w_pe_data = i_PE_Data;
`endif

  // Control FSM, loop counters and registered write outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_xlen   <= '0;
      r_pnum   <= '0;
      r_ylen   <= '0;
      r_base   <= '0;
      r_x      <= '0;
      r_piece  <= '0;
      r_y      <= '0;
      r_offset <= '0;
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      // Write and done are single-cycle unless re-asserted below.
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_AGUStart) begin
            r_xlen   <= i_Out_XLength;
            r_pnum   <= i_Input_PieceNum;
            r_ylen   <= i_Out_YLength;
            r_base   <= i_Out_BaseAddr;
            r_x      <= '0;
            r_piece  <= '0;
            r_y      <= '0;
            r_offset <= '0;
            if (w_empty) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRun;
              r_busy  <= 1'b1;
            end
          end
        end
        StRun: begin
          if (i_PE_Valid) begin
            r_wen    <= 1'b1;
            r_waddr  <= r_base + r_offset;
            r_wdata  <= w_pe_data;
            r_offset <= r_offset + AddrOne;
            if (w_x_max) begin
              r_x <= '0;
              if (w_p_max) begin
                r_piece <= '0;
                if (w_y_max) begin
                  r_y     <= '0;
                  r_state <= StDone;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_y <= r_y + 8'd1;
                end
              end else begin
                r_piece <= r_piece + 8'd1;
              end
            end else begin
              r_x <= r_x + 8'd1;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_IOB_WEn   = r_wen;
  assign o_IOB_WAddr = r_waddr;
  assign o_IOB_WData = r_wdata;
  assign o_AGU_Busy  = r_busy;
  assign o_AGU_Done  = r_done;

endmodule

// File: tb/tb_oagu_add.sv
// Bench for oagu_add: table of jobs driven cycle by cycle; a behavioural model
// pushes the expected output word per cycle into a queue, popped and compared
// one cycle later. Hand sequences cover reset state and reset mid-job.
module tb_oagu_add;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          i_clk;
  logic          i_rst_n;
  logic [7:0]    i_Input_PieceNum, i_Out_YLength, i_Out_XLength;
  logic [AW-1:0] i_Out_BaseAddr;
  logic          i_AGUStart, i_PE_Valid;
  logic [DW-1:0] i_PE_Data;
  logic          o_IOB_WEn, o_AGU_Busy, o_AGU_Done;
  logic [AW-1:0] o_IOB_WAddr;
  logic [DW-1:0] o_IOB_WData;

  oagu_add #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_Input_PieceNum (i_Input_PieceNum),
    .i_Out_YLength    (i_Out_YLength),
    .i_Out_XLength    (i_Out_XLength),
    .i_Out_BaseAddr   (i_Out_BaseAddr),
    .i_AGUStart       (i_AGUStart),
    .i_PE_Valid       (i_PE_Valid),
    .i_PE_Data        (i_PE_Data),
    .o_IOB_WEn        (o_IOB_WEn),
    .o_IOB_WAddr      (o_IOB_WAddr),
    .o_IOB_WData      (o_IOB_WData),
    .o_AGU_Busy       (o_AGU_Busy),
    .o_AGU_Done       (o_AGU_Done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Expected output word: {wen, addr, data, busy, done}
  typedef logic [AW+DW+2:0] obs_t;
  obs_t exp_q[$];

  typedef struct {
    logic [7:0]    x, p, y;
    logic [AW-1:0] base;
    logic [15:0]   vpat;     // bit c = valid in cycle c after start
    int            ncyc;
    int            start_at; // cycle of a stray mid-job start, -1 for none
    logic [DW-1:0] d0, dstep;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: 0 idle, 1 run, 2 done cycle
  int            m_phase = 0;
  int            m_k = 0;
  int            m_total = 0;
  logic [AW-1:0] m_base = '0;

  function automatic logic [DW-1:0] proc(input logic [DW-1:0] d);
`ifdef OAGU_ADD_RELU_EN
    return d[DW-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  function automatic obs_t pack(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic b, input logic dn);
    return {w, a, d, b, dn};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got wen=%0b addr=%h data=%h busy=%0b done=%0b, want wen=%0b addr=%h data=%h busy=%0b done=%0b",
               name, act[AW+DW+2], act[AW+DW+1:DW+2], act[DW+1:2], act[1], act[0],
               exp[AW+DW+2], exp[AW+DW+1:DW+2], exp[DW+1:2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle, push the model's expectation, compare after the edge.
  task automatic step(input string name, input logic start, input logic valid,
                      input logic [DW-1:0] data, input logic [7:0] x, input logic [7:0] p,
                      input logic [7:0] y, input logic [AW-1:0] base);
    logic    w, b, dn;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    obs_t    act;
    @(negedge i_clk);
    i_AGUStart = start; i_PE_Valid = valid; i_PE_Data = data;
    i_Out_XLength = x; i_Input_PieceNum = p; i_Out_YLength = y; i_Out_BaseAddr = base;
    w = 0; a = '0; d = '0; b = 0; dn = 0;
    case (m_phase)
      0: if (start) begin
        m_total = int'(x) * int'(p) * int'(y);
        m_base  = base;
        m_k     = 0;
        if (m_total == 0) begin dn = 1; m_phase = 2; end
        else begin b = 1; m_phase = 1; end
      end
      1: begin
        b = 1;
        if (valid) begin
          w = 1; a = m_base + AW'(m_k); d = proc(data);
          m_k++;
          if (m_k == m_total) begin b = 0; dn = 1; m_phase = 2; end
        end
      end
      default: m_phase = 0;
    endcase
    exp_q.push_back(pack(w, a, d, b, dn));
    @(posedge i_clk);
    #1;
    act = pack(o_IOB_WEn, o_IOB_WAddr, o_IOB_WData, o_AGU_Busy, o_AGU_Done);
    check(name, act, exp_q.pop_front());
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{x:2, p:2, y:2, base:12'h010, vpat:16'h00FF, ncyc:10, start_at:-1, d0:16'h1000, dstep:16'h0101};
    vecs[1] = '{x:3, p:1, y:1, base:12'h000, vpat:16'h0019, ncyc:7,  start_at:-1, d0:16'h0123, dstep:16'h0111};
    vecs[2] = '{x:0, p:5, y:5, base:12'h300, vpat:16'h000F, ncyc:5,  start_at:-1, d0:16'h0042, dstep:16'h0001};
    vecs[3] = '{x:4, p:1, y:1, base:12'hFFE, vpat:16'h000F, ncyc:6,  start_at:-1, d0:16'h7FFE, dstep:16'h0001};
    vecs[4] = '{x:4, p:2, y:1, base:12'h100, vpat:16'h00FF, ncyc:10, start_at:3,  d0:16'h8001, dstep:16'h1111};
    vecs[5] = '{x:2, p:1, y:1, base:12'h020, vpat:16'h0003, ncyc:4,  start_at:-1, d0:16'hFFF0, dstep:16'h0015};
    vecs[6] = '{x:1, p:3, y:2, base:12'h7F0, vpat:16'h00AF, ncyc:12, start_at:-1, d0:16'hC000, dstep:16'h2001};

    i_rst_n = 1'b0; i_AGUStart = 0; i_PE_Valid = 0; i_PE_Data = '0;
    i_Out_XLength = '0; i_Input_PieceNum = '0; i_Out_YLength = '0; i_Out_BaseAddr = '0;
    #1;
    check("reset_state", pack(o_IOB_WEn, o_IOB_WAddr, o_IOB_WData, o_AGU_Busy, o_AGU_Done), '0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      logic [DW-1:0] dv;
      int bk;
      bk = 0;
      // Valid while idle must be dropped.
      step($sformatf("v%0d_idle", v), 1'b0, 1'b1, 16'hDEAD, 8'd0, 8'd0, 8'd0, '0);
      step($sformatf("v%0d_start", v), 1'b1, 1'b0, 16'h0,
           vecs[v].x, vecs[v].p, vecs[v].y, vecs[v].base);
      for (int c = 0; c < vecs[v].ncyc; c++) begin
        logic vl;
        vl = vecs[v].vpat[c];
        dv = vl ? vecs[v].d0 + DW'(bk) * vecs[v].dstep : DW'($urandom);
        if (vl) bk++;
        // Config inputs scrambled after start: only latched copies may matter.
        step($sformatf("v%0d_c%0d", v, c), (c == vecs[v].start_at), vl, dv,
             8'(c + 1), 8'd0, 8'(7 - c), AW'($urandom));
      end
    end

    // Reset mid-job: outputs drop at once, no done, next job starts at base.
    step("rst_start", 1'b1, 1'b0, '0, 8'd4, 8'd2, 8'd1, 12'h040);
    step("rst_b0", 1'b0, 1'b1, 16'h0A0A, 8'd4, 8'd2, 8'd1, 12'h040);
    step("rst_b1", 1'b0, 1'b1, 16'h0B0B, 8'd4, 8'd2, 8'd1, 12'h040);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("rst_async", pack(o_IOB_WEn, o_IOB_WAddr, o_IOB_WData, o_AGU_Busy, o_AGU_Done), '0);
    @(posedge i_clk);
    #1;
    check("rst_hold", pack(o_IOB_WEn, o_IOB_WAddr, o_IOB_WData, o_AGU_Busy, o_AGU_Done), '0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    m_phase = 0;
    // After reset the FSM must be idle: a valid alone writes nothing.
    step("rst_idle", 1'b0, 1'b1, 16'h0C0C, 8'd4, 8'd2, 8'd1, 12'h040);
    step("rst_restart", 1'b1, 1'b0, '0, 8'd4, 8'd2, 8'd1, 12'h040);
    for (int c = 0; c < 9; c++)
      step($sformatf("rst_r%0d", c), 1'b0, (c != 4), 16'h0100 + 16'(c), 8'd9, 8'd9, 8'd9, 12'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/oagu_add.md
Name: oagu_add

Overview:
- Write-side address generator for the element-wise ADD path.
- Accepts the result stream from the PE array's ADD unit and produces IOB write-enable, address and data.
- Walks the same loop nest as the read-side generator: X innermost, then piece, then Y.
- Signals completion to the layer controller with a one-cycle done pulse.

Parameters:
- DATA_W, 16, width of the PE result and IOB write data
- ADDR_W, 12, IOB address width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_Input_PieceNum  in  8  pieces per row; 0 means empty job
- i_Out_YLength  in  8  output rows
- i_Out_XLength  in  8  output columns per piece
- i_Out_BaseAddr  in  ADDR_W  IOB write base address
- i_AGUStart  in  1  single-cycle start strobe
- i_PE_Valid  in  1  PE result valid
- i_PE_Data  in  DATA_W  PE result, two's complement
- o_IOB_WEn  out  1  IOB write enable
- o_IOB_WAddr  out  ADDR_W  IOB write address
- o_IOB_WData  out  DATA_W  IOB write data
- o_AGU_Busy  out  1  high while in RUN
- o_AGU_Done  out  1  one-cycle completion pulse

Behaviour:
- Reset: i_rst_n is asynchronous and active-low; the clock is i_clk. All outputs reset to 0. State resets to IDLE. Counters, offset and config latches reset to 0.
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - On i_AGUStart, latch XLength, PieceNum, YLength and BaseAddr, and clear x, piece and y counters and the write offset.
  - If any latched length is 0, go to DONE with no writes. Otherwise go to RUN.
  - i_PE_Valid is ignored.
- RUN:
  - o_AGU_Busy = 1.
  - Each cycle with i_PE_Valid = 1 is one beat. A cycle with valid = 0 does not advance any counter.
  - Per beat, next cycle: o_IOB_WEn = 1, o_IOB_WAddr = BaseAddr + offset (mod 2^ADDR_W), o_IOB_WData = processed i_PE_Data. Then offset increments by 1.
  - Write latency is exactly 1 cycle from valid. Back-to-back valids give back-to-back writes.
  - Counter order:
    - x wraps at XLength-1 to 0.
    - piece increments only when x wraps, and wraps at PieceNum-1.
    - y increments only when x and piece both wrap.
  - Last beat: x, piece and y are all at their maxima with valid = 1. On that edge, go to DONE and clear the counters.
- DONE:
  - Lasts one cycle with o_AGU_Done = 1, then returns to IDLE.
  - On a normal job the done pulse coincides with the final write (both 1 cycle after the last valid).
  - On an empty job the done pulse falls in the cycle after the start strobe.
- When o_IOB_WEn = 0, o_IOB_WAddr and o_IOB_WData are driven to 0.
- Outputs are all registered.
- i_AGUStart while in RUN or DONE is ignored; there is no restart mid-job.
- i_PE_Valid arriving in DONE or IDLE is dropped.
- Address wraps modulo 2^ADDR_W with no error flag.
- Beat count is X*P*Y, up to 255^3. The offset is ADDR_W bits and wraps.
- Config inputs may change after start; only the latched copies are used.
- Reset mid-job aborts immediately: no done pulse, WEn = 0.

Optional Feature:
- Macro: OAGU_ADD_RELU_EN.
- Defined: o_IOB_WData = 0 when i_PE_Data is negative (MSB = 1), else i_PE_Data. Applied in the same register stage, so latency is unchanged.
- Undefined: i_PE_Data passes through unmodified. No extra logic.

Test Plan:
- Continuous stream: X=2, P=2, Y=2, base 0x010, valid high 8 cycles.
  - Expect 8 writes at 0x010..0x017 on consecutive cycles, 1-cycle latency, data in order.
  - Expect o_AGU_Done together with the 0x017 write, Busy for exactly 8 cycles.
- Gapped valid: X=3, P=1, Y=1, valid pattern 1,0,0,1,1.
  - Expect writes at 0x000, 0x001, 0x002, each 1 cycle after its valid.
  - Expect no write in the gap cycles; done with the third write.
- Empty job: start with X=0.
  - Expect zero writes, o_AGU_Done one cycle after start, Busy never high.
- Address wrap: base 0xFFE, X=4, P=1, Y=1.
  - Expect addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Start and reset mid-job: X=4, P=2, Y=1.
  - Pulse start after 3 beats: ignored; the job completes at offset 7.
  - Rerun and assert reset after 2 beats: WEn = 0 immediately, no done, state IDLE.
  - A fresh start then begins again at base.
- With OAGU_ADD_RELU_EN, data 0xFFF0 then 0x0005: written as 0x0000 and 0x0005. Without the macro: 0xFFF0 and 0x0005.
